// File: rtl/bcd_counter_chain.sv
// Multi-digit BCD up/down counter with parallel load, wrap/saturate at the
// all-9/all-0 boundary and a sticky overflow flag.

module bcd_digit (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       step,
    input  logic       down,
    output logic [3:0] digit,
    output logic       bound
);
    assign bound = down ? (digit == 4'd0) : (digit == 4'd9);

    // Loads sanitise A-F to 0 and steps stay within 0-9, so the register is always BCD.
    always_ff @(posedge clock) begin
        if (reset)
            digit <= 4'd0;
        else if (load)
            digit <= (load_digit > 4'd9) ? 4'd0 : load_digit;
        else if (step) begin
            if (down)
                digit <= (digit == 4'd0) ? 4'd9 : digit - 4'd1;
            else
                digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
        end
    end
endmodule

module bcd_counter_chain #(
    parameter int NR_OF_DIGITS = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      countDown,
    input  logic                      saturate,
    input  logic                      load,
    input  logic [4*NR_OF_DIGITS-1:0] loadValue,
    input  logic                      clearOverflow,
    output logic [4*NR_OF_DIGITS-1:0] countValue,
    output logic [NR_OF_DIGITS-1:0]   digitCarry,
    output logic                      terminalCount,
    output logic                      isZero,
    output logic                      overflow
);
    logic [NR_OF_DIGITS-1:0] bound;
    logic [NR_OF_DIGITS-1:0] step;
    logic                    hold;

    // Saturation freezes every digit on the boundary step rather than letting it wrap.
    assign hold = saturate & digitCarry[NR_OF_DIGITS-1];

    for (genvar i = 0; i < NR_OF_DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign digitCarry[i] = enable & bound[i];
            assign step[i]       = enable & ~hold;
        end else begin : g_upper
            assign digitCarry[i] = digitCarry[i-1] & bound[i];
            assign step[i]       = digitCarry[i-1] & ~hold;
        end

        bcd_digit u_digit (
            .clock      (clock),
            .reset      (reset),
            .load       (load),
            .load_digit (loadValue[4*i +: 4]),
            .step       (step[i]),
            .down       (countDown),
            .digit      (countValue[4*i +: 4]),
            .bound      (bound[i])
        );
    end

    assign terminalCount = digitCarry[NR_OF_DIGITS-1] & ~reset & ~load;
    assign isZero        = (countValue == '0);

    // A boundary step beats a simultaneous clear.
    always_ff @(posedge clock) begin
        if (reset)
            overflow <= 1'b0;
        else if (terminalCount)
            overflow <= 1'b1;
        else if (clearOverflow)
            overflow <= 1'b0;
    end
endmodule
